data_memory_ctrl: RTL and testbench

- Parametrised successor to the single-cycle word data memory in the MIPS pipeline MEM stage.
- Adds byte, halfword and word access (sb/sh/sw, lb/lbu/lh/lhu/lw) with little-endian lane selection and sign/zero extension.
- Adds a one-cycle registered read with a req/ready/resp handshake, misalignment and range error reporting, and a post-reset clear sequence that zeroes the array.

---
 rtl/data_memory_ctrl_pkg.sv | 43 ++++
 rtl/dmem_load_align.sv | 30 +++
 rtl/data_memory_ctrl.sv | 135 +++++++++++++
 tb/tb_data_memory_ctrl.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/data_memory_ctrl_pkg.sv
// Shared encodings and store-lane helpers for the data memory controller.
package data_memory_ctrl_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned LANES  = 4;

  typedef enum logic [1:0] {
    SIZE_B   = 2'b00,
    SIZE_H   = 2'b01,
    SIZE_W   = 2'b10,
    SIZE_RSV = 2'b11
  } size_e;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_e;

  typedef struct packed {
    logic [LANES-1:0]  be;
    logic [DATA_W-1:0] data;
  } wr_bus_t;

  // Byte enables for a store of the given size at the given byte lane.
  function automatic logic [LANES-1:0] store_be(input logic [1:0] sz, input logic [1:0] lane);
    case (sz)
      SIZE_B:  store_be = 4'b0001 << lane;
      SIZE_H:  store_be = lane[1] ? 4'b1100 : 4'b0011;
      SIZE_W:  store_be = 4'b1111;
      default: store_be = 4'b0000;
    endcase
  endfunction

  // Replicate the low bits across the word so the byte enables pick the lane.
  function automatic logic [DATA_W-1:0] store_data(input logic [1:0] sz, input logic [DATA_W-1:0] d);
    case (sz)
      SIZE_B:  store_data = {4{d[7:0]}};
      SIZE_H:  store_data = {2{d[15:0]}};
      default: store_data = d;
    endcase
  endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load-path lane select with sign or zero extension.
module dmem_load_align
  import data_memory_ctrl_pkg::*;
(
  input  logic [DATA_W-1:0] word_in,
  input  logic [1:0]        lane,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  output logic [DATA_W-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lane)
      2'd0:    byte_sel = word_in[7:0];
      2'd1:    byte_sel = word_in[15:8];
      2'd2:    byte_sel = word_in[23:16];
      default: byte_sel = word_in[31:24];
    endcase
    half_sel = lane[1] ? word_in[31:16] : word_in[15:0];
    case (size)
      SIZE_B:  result = {{24{sign_ext & byte_sel[7]}}, byte_sel};
      SIZE_H:  result = {{16{sign_ext & half_sel[15]}}, half_sel};
      default: result = word_in;
    endcase
  end

endmodule

// File: rtl/data_memory_ctrl.sv
// Byte/half/word data memory with registered responses, error reporting
// and an optional post-reset zeroing sequence.
module data_memory_ctrl
  import data_memory_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH          = 256,
  parameter int unsigned ADDR_W         = 32,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              ready,
  output logic              resp_valid,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  output logic              init_done
);

  localparam int unsigned    IDX_W     = $clog2(DEPTH);
  localparam int unsigned    WADDR_W   = ADDR_W - 2;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
  localparam state_e         RST_STATE = CLEAR_ON_RESET ? ST_CLEAR : ST_IDLE;

  state_e             state, state_next;
  logic [IDX_W-1:0]   cnt, cnt_next;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic [WADDR_W-1:0] word_addr;
  logic [IDX_W-1:0]   idx;
  logic               oor;
  logic               req_err;
  logic               accept;
  wr_bus_t            wr;
  logic [IDX_W-1:0]   wr_idx;
  logic [DATA_W-1:0]  ld_result;

  assign word_addr = addr[ADDR_W-1:2];
  assign idx       = word_addr[IDX_W-1:0];
  assign accept    = req & ready;

  // Any word-address bit above the array index means out of range.
  generate
    if (WADDR_W > IDX_W) begin : g_oor
      assign oor = |word_addr[WADDR_W-1:IDX_W];
    end else begin : g_no_oor
      assign oor = 1'b0;
    end
  endgenerate

  always_comb begin
    req_err = oor;
    case (size)
      SIZE_H:  if (addr[0]) req_err = 1'b1;
      SIZE_W:  if (addr[1:0] != 2'b00) req_err = 1'b1;
      SIZE_RSV: req_err = 1'b1;
      default: ;
    endcase
  end

  // Single write port shared by the clear sequence and accepted stores.
  always_comb begin
    wr     = '0;
    wr_idx = idx;
    if (state == ST_CLEAR) begin
      wr.be  = '1;
      wr_idx = cnt;
    end else if (accept && we && !req_err) begin
      wr.be   = store_be(size, addr[1:0]);
      wr.data = store_data(size, wdata);
    end
  end

  always_ff @(posedge clk) begin
    for (int b = 0; b < int'(LANES); b++) begin
      if (wr.be[b]) mem[wr_idx][8*b +: 8] <= wr.data[8*b +: 8];
    end
  end

  dmem_load_align u_load_align (
    .word_in  (mem[idx]),
    .lane     (addr[1:0]),
    .size     (size),
    .sign_ext (sign_ext),
    .result   (ld_result)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RST_STATE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      ST_CLEAR: begin
        cnt_next = cnt + IDX_W'(1);
        if (cnt == LAST_IDX) begin
          state_next = ST_IDLE;
          cnt_next   = '0;
        end
      end
      ST_IDLE: ;
      default: state_next = RST_STATE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready      <= 1'b0;
      init_done  <= 1'b0;
      resp_valid <= 1'b0;
      err        <= 1'b0;
      rdata      <= '0;
    end else begin
      ready      <= (state_next == ST_IDLE);
      init_done  <= (state_next == ST_IDLE);
      resp_valid <= accept;
      err        <= accept & req_err;
      rdata      <= (accept && !we && !req_err) ? ld_result : '0;
    end
  end

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Self-checking bench for data_memory_ctrl: directed table, hand sequences,
// and randomized traffic against a word-array reference model.
module tb_data_memory_ctrl;

  localparam int unsigned DEPTH = 256;

  logic        clk, rst_n, req, we, sign_ext;
  logic [1:0]  size;
  logic [31:0] addr, wdata;
  logic        ready, resp_valid, err, init_done;
  logic [31:0] rdata;

  int checks = 0;
  int errors = 0;

  logic [31:0] mm [DEPTH];

  data_memory_ctrl #(.DEPTH(DEPTH), .ADDR_W(32), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size),
    .sign_ext(sign_ext), .addr(addr), .wdata(wdata), .ready(ready),
    .resp_valid(resp_valid), .rdata(rdata), .err(err), .init_done(init_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        sx;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input logic w, input logic [1:0] s, input logic sx,
                              input logic [31:0] a, input logic [31:0] d,
                              input logic [31:0] r, input logic e);
    vec_t v;
    v.we = w; v.size = s; v.sx = sx; v.addr = a; v.wdata = d; v.exp_rd = r; v.exp_err = e;
    vecs.push_back(v);
  endfunction

  // Reference: memory as whole words, access computed with shifts and masks.
  function automatic void model(input logic w, input logic [1:0] s, input logic sx,
                                input logic [31:0] a, input logic [31:0] d,
                                output logic [31:0] rd, output logic e);
    int unsigned wi, sh;
    logic [31:0] mask;
    wi   = a >> 2;
    sh   = 8 * int'(a[1:0]);
    mask = (s == 2'd0) ? 32'hFF : (s == 2'd1) ? 32'hFFFF : 32'hFFFF_FFFF;
    e    = (s == 2'd3) || (s == 2'd1 && a[0]) || (s == 2'd2 && a[1:0] != 2'b00) || (wi >= DEPTH);
    rd   = 32'h0;
    if (!e) begin
      if (w) begin
        mm[wi] = (mm[wi] & ~(mask << sh)) | ((d & mask) << sh);
      end else begin
        rd = (mm[wi] >> sh) & mask;
        if (sx && ((rd & ~(mask >> 1)) != 0)) rd = rd | ~mask;
      end
    end
  endfunction

  task automatic drive(input logic w, input logic [1:0] s, input logic sx,
                       input logic [31:0] a, input logic [31:0] d);
    req = 1'b1; we = w; size = s; sign_ext = sx; addr = a; wdata = d;
  endtask

  // Counts clocks until ready rises with a lw request held, which must be ignored.
  task automatic wait_clear(input int exp_cycles);
    int n;
    int stray;
    n = 0; stray = 0;
    drive(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
    while (!ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
      if (resp_valid) stray++;
    end
    req = 1'b0;
    check("clear_cycles", n, exp_cycles);
    check("clear_no_resp", stray, 0);
    check("init_done", {31'b0, init_done}, 32'd1);
    for (int i = 0; i < int'(DEPTH); i++) mm[i] = 32'h0;
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] erd;
    logic        eerr;
    logic        prev_req;
    logic [31:0] prev_rd;
    logic        prev_err;

    clk = 0; rst_n = 0; req = 0; we = 0; size = 0; sign_ext = 0; addr = 0; wdata = 0;
    repeat (3) @(negedge clk);
    check("rst_ready", {31'b0, ready}, 0);
    check("rst_resp_valid", {31'b0, resp_valid}, 0);
    check("rst_rdata", rdata, 0);
    check("rst_err", {31'b0, err}, 0);
    check("rst_init_done", {31'b0, init_done}, 0);
    rst_n = 1'b1;
    wait_clear(256);

    // we, size, sx, addr, wdata, expected rdata, expected err
    add(0, 2, 0, 32'h3FC, 32'h0,        32'h0000_0000, 0);
    add(1, 2, 0, 32'h10,  32'h80FF7F01, 32'h0,         0);
    add(0, 0, 1, 32'h11,  32'h0,        32'h0000_007F, 0);
    add(0, 0, 0, 32'h11,  32'h0,        32'h0000_007F, 0);
    add(0, 1, 1, 32'h12,  32'h0,        32'hFFFF_80FF, 0);
    add(0, 1, 0, 32'h12,  32'h0,        32'h0000_80FF, 0);
    add(0, 0, 1, 32'h10,  32'h0,        32'h0000_0001, 0);
    add(0, 0, 1, 32'h13,  32'h0,        32'hFFFF_FF80, 0);
    add(0, 1, 1, 32'h10,  32'h0,        32'h0000_7F01, 0);
    add(1, 2, 0, 32'h20,  32'h11223344, 32'h0,         0);
    add(1, 0, 0, 32'h21,  32'hFFFFFFAA, 32'h0,         0);
    add(0, 2, 0, 32'h20,  32'h0,        32'h1122_AA44, 0);
    add(1, 1, 0, 32'h22,  32'h1234BEEF, 32'h0,         0);
    add(0, 2, 0, 32'h20,  32'h0,        32'hBEEF_AA44, 0);
    add(0, 1, 1, 32'h22,  32'h0,        32'hFFFF_BEEF, 0);
    add(0, 1, 0, 32'h22,  32'h0,        32'h0000_BEEF, 0);
    add(0, 1, 1, 32'h13,  32'h0,        32'h0,         1);
    add(0, 2, 0, 32'h22,  32'h0,        32'h0,         1);
    add(0, 3, 0, 32'h0,   32'h0,        32'h0,         1);
    add(0, 2, 0, 32'h400, 32'h0,        32'h0,         1);
    add(1, 1, 0, 32'h13,  32'h12345678, 32'h0,         1);
    add(1, 2, 0, 32'h22,  32'h12345678, 32'h0,         1);
    add(1, 3, 0, 32'h0,   32'h12345678, 32'h0,         1);
    add(1, 2, 0, 32'h400, 32'h12345678, 32'h0,         1);
    add(0, 2, 0, 32'h10,  32'h0,        32'h80FF_7F01, 0);
    add(0, 2, 0, 32'h20,  32'h0,        32'hBEEF_AA44, 0);
    add(0, 2, 0, 32'h0,   32'h0,        32'h0,         0);
    add(0, 2, 0, 32'h3FC, 32'h0,        32'h0,         0);

    // Vectors are issued on consecutive clocks.
    foreach (vecs[i]) begin
      drive(vecs[i].we, vecs[i].size, vecs[i].sx, vecs[i].addr, vecs[i].wdata);
      model(vecs[i].we, vecs[i].size, vecs[i].sx, vecs[i].addr, vecs[i].wdata, erd, eerr);
      @(posedge clk); @(negedge clk);
      check($sformatf("vec%0d_valid", i), {31'b0, resp_valid}, 1);
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rd);
      check($sformatf("vec%0d_err", i), {31'b0, err}, {31'b0, vecs[i].exp_err});
    end
    req = 1'b0;
    @(posedge clk); @(negedge clk);
    check("idle_no_resp", {31'b0, resp_valid}, 0);

    // Store then load of the same word on successive edges.
    drive(1, 2, 0, 32'h8, 32'hDEADBEEF);
    model(1, 2, 0, 32'h8, 32'hDEADBEEF, erd, eerr);
    @(posedge clk); @(negedge clk);
    check("b2b_st_valid", {31'b0, resp_valid}, 1);
    check("b2b_st_rdata", rdata, 0);
    drive(0, 2, 0, 32'h8, 32'h0);
    @(posedge clk); @(negedge clk);
    req = 1'b0;
    check("b2b_ld_valid", {31'b0, resp_valid}, 1);
    check("b2b_ld_rdata", rdata, 32'hDEADBEEF);
    @(posedge clk); @(negedge clk);
    check("b2b_after_valid", {31'b0, resp_valid}, 0);

    // Randomized traffic with idle gaps against the model.
    prev_req = 1'b0; prev_rd = 0; prev_err = 0;
    for (int i = 0; i < 400; i++) begin
      logic        w, sx, go;
      logic [1:0]  s;
      logic [31:0] a, d;
      go = ($urandom_range(0, 9) < 8);
      w  = $urandom_range(0, 1);
      sx = $urandom_range(0, 1);
      s  = ($urandom_range(0, 19) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      a  = ($urandom_range(0, 19) == 0) ? $urandom : 32'($urandom_range(0, 32'h3FF));
      if ($urandom_range(0, 3) != 0) begin
        if (s == 2'd1) a[0] = 1'b0;
        if (s == 2'd2) a[1:0] = 2'b00;
      end
      d = $urandom;
      if (go) begin
        drive(w, s, sx, a, d);
        model(w, s, sx, a, d, erd, eerr);
      end else begin
        req = 1'b0; addr = $urandom; wdata = $urandom;
      end
      @(posedge clk); @(negedge clk);
      check("rnd_valid", {31'b0, resp_valid}, {31'b0, go});
      if (go) begin
        check("rnd_rdata", rdata, erd);
        check("rnd_err", {31'b0, err}, {31'b0, eerr});
      end
    end
    req = 1'b0;

    // Reset in the middle of the clear sequence restarts it from zero.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midclr_ready", {31'b0, ready}, 0);
    check("midclr_init_done", {31'b0, init_done}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear(256);
    drive(0, 2, 0, 32'h8, 32'h0);
    @(posedge clk); @(negedge clk);
    req = 1'b0;
    check("cleared_word", rdata, 32'h0);

    // Reset while a response is on the outputs drops it at once.
    drive(0, 2, 0, 32'h3FC, 32'h0);
    @(posedge clk); #1;
    req = 1'b0;
    check("pend_valid_before", {31'b0, resp_valid}, 1);
    rst_n = 1'b0;
    #1;
    check("pend_valid_rst", {31'b0, resp_valid}, 0);
    check("pend_rdata_rst", rdata, 0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear(256);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
